led_trail_pwm: RTL and testbench

- Downstream stage for the 8-LED sweep pattern generator; consumes its 8-bit pattern word.
- Each LED keeps a brightness level that jumps to full while its pattern bit is 1. The level then decays in steps after the bit drops, producing a fading "comet trail".
- Levels drive per-LED PWM outputs directly to the board LEDs.
- A debug port exposes any LED's current level to the bench.

---
 rtl/led_trail_pwm_if.sv | 26 ++
 rtl/led_trail_pwm.sv | 104 ++++++++++
 tb/tb_led_trail_pwm.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/led_trail_pwm_if.sv
// Bus between the LED trail/PWM stage and its neighbours.
//   enable    : 1 = run, 0 = freeze state and blank the LEDs
//   patternIn : 8-bit sweep pattern word, sampled every cycle
//   ledOut    : registered PWM drive, one bit per LED
//   levelSel  : debug selector, LED index 0..7
//   levelOut  : brightness level of the selected LED (combinational)
// master drives the pattern, enable and selector; slave is the trail stage.
interface led_trail_pwm_if #(
  parameter int PWM_BITS = 4
);
  logic                enable;
  logic [7:0]          patternIn;
  logic [7:0]          ledOut;
  logic [2:0]          levelSel;
  logic [PWM_BITS-1:0] levelOut;

  modport master (
    output enable, patternIn, levelSel,
    input  ledOut, levelOut
  );

  modport slave (
    input  enable, patternIn, levelSel,
    output ledOut, levelOut
  );
endinterface

// File: rtl/led_trail_pwm.sv
// Comet-trail brightness and PWM stage behind the 8-LED sweep generator.
// Each LED holds a brightness level that jumps to full while its pattern
// bit is set, then decays by DECAY_STEP every DECAY_COUNT enabled cycles.
// Levels are turned into PWM drive against a shared free-running counter.
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : led_trail_pwm_if.slave (enable, patternIn, ledOut, levelSel, levelOut)

// One LED: brightness level register plus its PWM output flop.
module led_trail_lane #(
  parameter int PWM_BITS   = 4,
  parameter int DECAY_STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                load,     // registered pattern bit
  input  logic                tick,     // shared decay tick
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] level,
  output logic                led
);
  localparam logic [PWM_BITS-1:0] LMAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      if (enable) begin
        // A live pattern bit wins over a decay tick in the same cycle.
        if (load)
          level <= LMAX;
        else if (tick)
          level <= (level >= STEP) ? level - STEP : '0;
      end
      // Full level is forced solid so it never shows a one-cycle gap when
      // the counter sits at LMAX.
      led <= enable && ((level == LMAX) || (level > pwm_cnt));
    end
  end
endmodule

module led_trail_pwm #(
  parameter int PWM_BITS    = 4,
  parameter int DECAY_COUNT = 16,
  parameter int DECAY_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  led_trail_pwm_if.slave  bus
);
  localparam int NUM_LANES = 8;
  // Keep the counter at least one bit wide so DECAY_COUNT=1 elaborates.
  localparam int CW = (DECAY_COUNT > 1) ? $clog2(DECAY_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECAY_COUNT - 1);

  logic [NUM_LANES-1:0]               pat_q;
  logic [CW-1:0]                      decay_cnt;
  logic                               decay_tick;
  logic [PWM_BITS-1:0]                pwm_cnt;
  logic [NUM_LANES-1:0][PWM_BITS-1:0] level;
  logic [NUM_LANES-1:0]               led;

  // Pattern is registered unconditionally so enable only gates the update.
  always_ff @(posedge clk) begin
    if (rst) pat_q <= '0;
    else     pat_q <= bus.patternIn;
  end

  // Decay timer and PWM counter both freeze while disabled, so a re-enable
  // resumes the fade exactly where it stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      decay_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (bus.enable) begin
      decay_cnt <= (decay_cnt == CNT_LAST) ? '0 : decay_cnt + CW'(1);
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
    end
  end

  assign decay_tick = bus.enable && (decay_cnt == CNT_LAST);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    led_trail_lane #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .enable  (bus.enable),
      .load    (pat_q[g]),
      .tick    (decay_tick),
      .pwm_cnt (pwm_cnt),
      .level   (level[g]),
      .led     (led[g])
    );
  end

  assign bus.ledOut   = led;
  assign bus.levelOut = level[bus.levelSel];
endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm. Main instance uses DECAY_COUNT=4,
// DECAY_STEP=4; a second instance with DECAY_COUNT=1000 holds a level
// steady for the PWM duty measurement. Both share the same stimulus.
module tb_led_trail_pwm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_trail_pwm_if #(.PWM_BITS(4)) bus  ();
  led_trail_pwm_if #(.PWM_BITS(4)) bus2 ();

  assign bus2.enable    = bus.enable;
  assign bus2.patternIn = bus.patternIn;
  assign bus2.levelSel  = bus.levelSel;

  led_trail_pwm #(.PWM_BITS(4), .DECAY_COUNT(4), .DECAY_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  led_trail_pwm #(.PWM_BITS(4), .DECAY_COUNT(1000), .DECAY_STEP(4)) dut_hold (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] pat;
    logic [2:0] sel;
    logic [7:0] led;   // expected ledOut after the edge
    logic [3:0] lvl;   // expected levelOut after the edge
  } vec_t;

  vec_t vt[$];
  int   total  = 0;
  int   passed = 0;

  task automatic add(input logic r, input logic e, input logic [7:0] p,
                     input logic [2:0] s, input logic [7:0] l, input logic [3:0] v);
    vec_t x;
    x.rst = r; x.en = e; x.pat = p; x.sel = s; x.led = l; x.lvl = v;
    vt.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;
    int n;

    rst = 1'b1;
    bus.enable = 1'b1;
    bus.patternIn = 8'h00;
    bus.levelSel = 3'd0;

    // Reset with pattern all ones, then release: L full one edge after the
    // sample edge, ledOut full one edge after that.
    add(1, 1, 8'hFF, 0, 8'h00, 0);
    add(1, 1, 8'hFF, 7, 8'h00, 0);
    add(0, 1, 8'hFF, 7, 8'h00, 0);
    add(0, 1, 8'hFF, 7, 8'h00, 15);
    add(0, 1, 8'hFF, 4, 8'hFF, 15);
    // Latency / solid-on with 8'h81 held.
    add(1, 1, 8'h81, 0, 8'h00, 0);
    add(0, 1, 8'h81, 0, 8'h00, 0);
    add(0, 1, 8'h81, 0, 8'h00, 15);
    add(0, 1, 8'h81, 0, 8'h81, 15);
    add(0, 1, 8'h81, 7, 8'h81, 15);
    add(0, 1, 8'h81, 1, 8'h81, 0);
    // Decay of LEDs 2 and 3 (E0 = reset edge). Ticks at E4, E8, E12, E16.
    add(1, 1, 8'h0C, 3, 8'h00, 0);   // E0
    add(0, 1, 8'h0C, 3, 8'h00, 0);   // E1 sample
    add(0, 1, 8'h00, 3, 8'h00, 15);  // E2 L=15
    add(0, 1, 8'h00, 3, 8'h0C, 15);  // E3
    add(0, 1, 8'h00, 3, 8'h0C, 11);  // E4 tick
    add(0, 1, 8'h00, 3, 8'h0C, 11);  // E5 pwm 4
    add(0, 1, 8'h00, 3, 8'h0C, 11);  // E6
    add(0, 1, 8'h00, 3, 8'h0C, 11);  // E7
    add(0, 1, 8'h00, 3, 8'h0C, 7);   // E8 tick
    add(0, 1, 8'h00, 3, 8'h00, 7);   // E9 7 > 8 false
    add(0, 1, 8'h00, 3, 8'h00, 7);   // E10
    add(0, 1, 8'h04, 3, 8'h00, 7);   // E11 LED2 bit sampled
    add(0, 1, 8'h00, 2, 8'h00, 15);  // E12 tick + load: LED2 15 not 3
    add(0, 1, 8'h00, 3, 8'h04, 3);   // E13 LED3 decayed to 3
    add(0, 1, 8'h00, 2, 8'h04, 15);  // E14
    add(0, 1, 8'h00, 3, 8'h04, 3);   // E15
    add(0, 1, 8'h00, 3, 8'h04, 0);   // E16 tick: 3 -> 0 saturates
    add(0, 1, 8'h00, 2, 8'h04, 11);  // E17
    // Freeze 20 cycles: LEDs blank, level held.
    for (int i = 0; i < 20; i++) add(0, 0, 8'h00, 2, 8'h00, 11);
    // Resume: counters pick up at cnt=1, pwm=1.
    add(0, 1, 8'h00, 2, 8'h04, 11);
    add(0, 1, 8'h00, 2, 8'h04, 11);
    add(0, 1, 8'h00, 2, 8'h04, 7);   // tick exactly 3 enabled edges later
    add(0, 1, 8'h00, 2, 8'h04, 7);
    add(0, 1, 8'h00, 2, 8'h04, 7);
    add(0, 1, 8'h00, 2, 8'h04, 7);   // 7 > pwm 6
    add(0, 1, 8'h00, 2, 8'h00, 3);   // 7 > pwm 7 false; tick
    // Mid-fade reset clears everything.
    add(1, 1, 8'h00, 2, 8'h00, 0);
    add(0, 1, 8'h00, 2, 8'h00, 0);
    add(0, 1, 8'h00, 3, 8'h00, 0);

    foreach (vt[i]) begin
      rst = vt[i].rst;
      bus.enable = vt[i].en;
      bus.patternIn = vt[i].pat;
      bus.levelSel = vt[i].sel;
      step();
      chk("ledOut", i, int'(bus.ledOut), int'(vt[i].led));
      chk("levelOut", i, int'(bus.levelOut), int'(vt[i].lvl));
    end

    // PWM duty on the slow-decay instance: LED5 reaches 7 after two ticks.
    rst = 1'b1; bus.enable = 1'b1; bus.patternIn = 8'h00; bus.levelSel = 3'd5;
    step();
    rst = 1'b0; bus.patternIn = 8'h20;
    step();
    bus.patternIn = 8'h00;
    step();
    chk("hold_full", 0, int'(bus2.levelOut), 15);
    n = 0;
    while (bus2.levelOut != 4'd7 && n < 2500) begin
      step();
      n++;
    end
    chk("hold_reach7", 0, int'(bus2.levelOut), 7);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      hi += int'(bus2.ledOut[5]);
    end
    chk("duty16", 0, hi, 7);
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      hi += int'(bus2.ledOut[5]);
    end
    chk("duty32", 0, hi, 14);
    chk("hold_still7", 0, int'(bus2.levelOut), 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
